multi_clock_generator: RTL and testbench

MULTI_CLOCK_GENERATOR -- requirements
Module: multi_clock_generator

---
 rtl/multi_clock_generator_if.sv | 28 ++
 rtl/multi_clock_generator.sv | 100 ++++++++++
 tb/tb_multi_clock_generator.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_clock_generator_if.sv
// Bundle of run requests, half-period settings and generated clock outputs
// for a bank of independent divided-clock channels.
interface multi_clock_generator_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
);
    logic [CHANNELS-1:0]       work;
    logic [CHANNELS*WIDTH-1:0] half_period;
    logic [CHANNELS-1:0]       clk_out;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       rise;

    modport master (
        output work,
        output half_period,
        input  clk_out,
        input  busy,
        input  rise
    );

    modport slave (
        input  work,
        input  half_period,
        output clk_out,
        output busy,
        output rise
    );
endinterface

// File: rtl/multi_clock_generator.sv
// Bank of independent 50%-duty clock dividers. Each channel runs whole periods
// of 2*H system cycles while requested and always stops low after a full period.
module multi_clock_generator #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    multi_clock_generator_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        state_t           state_reg, state_next;
        logic [WIDTH-1:0] cnt_reg, cnt_next;
        logic             clk_out_reg, clk_out_next;
        logic             busy_reg, busy_next;
        logic             rise_reg, rise_next;
        logic [WIDTH-1:0] hp;
        logic [WIDTH-1:0] reload;

        // A half-period of 0 runs as 1, so the reload value is never negative.
        assign hp     = bus.half_period[gi*WIDTH +: WIDTH];
        assign reload = (hp == '0) ? '0 : hp - WIDTH'(1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_reg   <= ST_IDLE;
                cnt_reg     <= '0;
                clk_out_reg <= 1'b0;
                busy_reg    <= 1'b0;
                rise_reg    <= 1'b0;
            end else begin
                state_reg   <= state_next;
                cnt_reg     <= cnt_next;
                clk_out_reg <= clk_out_next;
                busy_reg    <= busy_next;
                rise_reg    <= rise_next;
            end
        end

        always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            clk_out_next = clk_out_reg;
            rise_next    = 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    clk_out_next = 1'b0;
                    if (bus.work[gi]) begin
                        state_next   = ST_HIGH;
                        clk_out_next = 1'b1;
                        rise_next    = 1'b1;
                        cnt_next     = reload;
                    end
                end
                ST_HIGH: begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - WIDTH'(1);
                    end else begin
                        state_next   = ST_LOW;
                        clk_out_next = 1'b0;
                        cnt_next     = reload;
                    end
                end
                ST_LOW: begin
                    // work is only looked at on the last low cycle, so a period
                    // in progress always completes.
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - WIDTH'(1);
                    end else if (bus.work[gi]) begin
                        state_next   = ST_HIGH;
                        clk_out_next = 1'b1;
                        rise_next    = 1'b1;
                        cnt_next     = reload;
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next   = ST_IDLE;
                    cnt_next     = '0;
                    clk_out_next = 1'b0;
                end
            endcase
            busy_next = (state_next != ST_IDLE);
        end

        assign bus.clk_out[gi] = clk_out_reg;
        assign bus.busy[gi]    = busy_reg;
        assign bus.rise[gi]    = rise_reg;
    end

endmodule

// File: tb/tb_multi_clock_generator.sv
// Randomised and directed stimulus for the clock divider bank; expected outputs
// come from a phase-length model and are checked by a decoupled monitor.
module tb_multi_clock_generator;
    localparam int CH = 4;
    localparam int W  = 4;

    typedef struct packed {
        logic [CH-1:0] c;
        logic [CH-1:0] b;
        logic [CH-1:0] r;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    // Model: per channel, whether a period is running, which half, cycles left.
    bit m_act  [CH];
    bit m_hi   [CH];
    int m_left [CH];

    multi_clock_generator_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    multi_clock_generator #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_act[i]  = 1'b0;
            m_hi[i]   = 1'b0;
            m_left[i] = 0;
        end
    endfunction

    function automatic exp_t model_edge();
        exp_t e;
        int   h;
        e = '0;
        for (int i = 0; i < CH; i++) begin
            h = int'(bus.half_period[i*W +: W]);
            if (h == 0) h = 1;
            if (!m_act[i]) begin
                if (bus.work[i]) begin
                    m_act[i] = 1'b1; m_hi[i] = 1'b1; m_left[i] = h; e.r[i] = 1'b1;
                end
            end else begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    if (m_hi[i]) begin
                        m_hi[i] = 1'b0; m_left[i] = h;
                    end else if (bus.work[i]) begin
                        m_hi[i] = 1'b1; m_left[i] = h; e.r[i] = 1'b1;
                    end else begin
                        m_act[i] = 1'b0;
                    end
                end
            end
            e.c[i] = m_act[i] && m_hi[i];
            e.b[i] = m_act[i];
        end
        return e;
    endfunction

    task automatic check_vec(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    // Monitor: the DUT presents a fresh output word after every clock edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_vec("clk_out", bus.clk_out, e.c);
            check_vec("busy", bus.busy, e.b);
            check_vec("rise", bus.rise, e.r);
            $display("cycle t=%0t work=%b clk_out=%b busy=%b rise=%b", $time,
                     bus.work, bus.clk_out, bus.busy, bus.rise);
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            exp_q.push_back(model_edge());
            #1;
        end
    endtask

    task automatic set_hp(input int ch, input int val);
        bus.half_period[ch*W +: W] = W'(val);
    endtask

    task automatic check_zero(input string name);
        check_vec({name, "_clk_out"}, bus.clk_out, '0);
        check_vec({name, "_busy"}, bus.busy, '0);
        check_vec({name, "_rise"}, bus.rise, '0);
    endtask

    // Asserted between edges, after the monitor has sampled the last edge.
    task automatic reset_mid();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("held_rst");
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.work = '0;
        bus.half_period = '0;
        model_reset();
        #1;
        check_zero("reset");
        bus.work = '1;
        set_hp(0, 3); set_hp(1, 4); set_hp(2, 5); set_hp(3, 6);
        @(posedge clk);
        #1;
        check_zero("reset_edge");
        #2;
        rst = 1'b0;
        bus.work = '0;

        // Basic: channel 0 at H=3 for 20 cycles.
        bus.work = 4'b0001;
        step(20);
        bus.work = '0;
        step(8);

        // Graceful stop: channel 1 drops work on its second high cycle.
        bus.work = 4'b0010;
        step(2);
        bus.work = '0;
        step(10);

        // H=0 and H=1 side by side must match.
        set_hp(2, 0); set_hp(3, 1);
        bus.work = 4'b1100;
        step(10);
        bus.work = '0;
        step(4);

        // Reprogram 2 -> 5 in the middle of a high phase.
        set_hp(0, 2);
        bus.work = 4'b0001;
        step(1);
        set_hp(0, 5);
        step(14);
        bus.work = '0;
        step(12);

        // Largest half-period.
        set_hp(3, 15);
        bus.work = 4'b1000;
        step(3);
        bus.work = '0;
        step(30);

        // Async reset while high, then restart on the first edge.
        set_hp(0, 4);
        bus.work = 4'b0001;
        step(2);
        reset_mid();
        step(3);
        bus.work = '0;
        step(8);

        // Independence: fixed half-periods, staggered random work.
        set_hp(0, 1); set_hp(1, 2); set_hp(2, 3); set_hp(3, 7);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) bus.work[$urandom_range(0, CH-1)] ^= 1'b1;
            step(1);
        end

        // Fully random work and half-period changes, with an occasional reset.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 4) == 0) bus.work = CH'($urandom);
            if ($urandom_range(0, 9) == 0) set_hp($urandom_range(0, CH-1), $urandom_range(0, 15));
            if (k == 700) reset_mid();
            step(1);
        end
        bus.work = '0;
        step(35);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
